// File: rtl/trng_health_fifo.sv
// Entropy conditioning ahead of asic_top: startup discard, repetition-count health test,
// output FIFO with a request/strobe handshake. Define TRNG_APT_EN to add the adaptive proportion test.
module trng_health_fifo #(
    parameter int DEPTH         = 8,
    parameter int STARTUP_WORDS = 16,
    parameter int RCT_CUTOFF    = 4,
    parameter int APT_WINDOW    = 64,
    parameter int APT_CUTOFF    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            raw_data,
    input  logic                   raw_valid,
    output logic                   raw_ready,
    input  logic                   trng_request,
    output logic [31:0]            trng_data,
    output logic                   trng_ready,
    input  logic                   clear_alarm,
    output logic                   alarm,
    output logic [1:0]             health_state,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARTUP_WORDS + 1);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] START_LAST = SW'(STARTUP_WORDS - 1);
    localparam logic [RW-1:0] RCT_LIMIT  = RW'(RCT_CUTOFF);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_start_cnt;
    logic [RW-1:0] r_rct_cnt;
    logic [RW-1:0] w_rct_next;
    logic [31:0]   r_last_word;
    logic [31:0]   r_trng_data;
    logic          r_trng_ready;
    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_rct_trip;
    logic          w_apt_trip;
    logic          w_trip;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_clear;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign raw_ready = !rst && !w_full && (r_state != ST_ALARM);
    assign w_accept  = raw_valid && raw_ready;
    assign w_clear   = (r_state == ST_ALARM) && clear_alarm;

    // A zero count marks "no word accepted yet", so the first compare always restarts at 1.
    assign w_rct_next = ((r_rct_cnt != '0) && (raw_data == r_last_word)) ? r_rct_cnt + 1'b1 : RW'(1);
    assign w_rct_trip = w_accept && (w_rct_next == RCT_LIMIT);
    assign w_trip     = w_rct_trip || w_apt_trip;

    assign w_push  = w_accept && (r_state == ST_RUN) && !w_trip;
    assign w_pop   = trng_request && !w_empty && !r_trng_ready && (r_state != ST_ALARM);
    assign w_flush = (r_state != ST_ALARM) && (w_state_next == ST_ALARM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_STARTUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_STARTUP: begin
                if (w_trip) begin
                    w_state_next = ST_ALARM;
                end else if (w_accept && (r_start_cnt == START_LAST)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_trip) begin
                    w_state_next = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (clear_alarm) begin
                    w_state_next = ST_STARTUP;
                end
            end
            default: w_state_next = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_start_cnt <= '0;
            r_rct_cnt   <= '0;
            r_last_word <= '0;
        end else if (w_accept) begin
            r_rct_cnt   <= w_rct_next;
            r_last_word <= raw_data;
            if (r_state == ST_STARTUP && !w_trip) begin
                r_start_cnt <= r_start_cnt + 1'b1;
            end
        end
    end

    // Storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= raw_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A pop decided in the tripping cycle still delivers its word; the flush only empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trng_data  <= '0;
            r_trng_ready <= 1'b0;
        end else begin
            r_trng_ready <= w_pop;
            if (w_pop) begin
                r_trng_data <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef TRNG_APT_EN
    localparam int PW = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;
    localparam int AC = $clog2(APT_CUTOFF + 1);
    localparam logic [PW-1:0] APT_LAST  = PW'(APT_WINDOW - 1);
    localparam logic [AC-1:0] APT_LIMIT = AC'(APT_CUTOFF);

    logic [PW-1:0] r_apt_pos;
    logic [AC-1:0] r_apt_cnt;
    logic [31:0]   r_apt_ref;
    logic          w_apt_match;
    logic [AC-1:0] w_apt_cnt_next;

    assign w_apt_match    = (r_apt_pos != '0) && (raw_data == r_apt_ref);
    assign w_apt_cnt_next = r_apt_cnt + AC'(w_apt_match);
    assign w_apt_trip     = w_accept && w_apt_match && (w_apt_cnt_next == APT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_apt_pos <= '0;
            r_apt_cnt <= '0;
            r_apt_ref <= '0;
        end else if (w_accept) begin
            if (r_apt_pos == '0) begin
                r_apt_ref <= raw_data;
                r_apt_cnt <= '0;
            end else begin
                r_apt_cnt <= w_apt_cnt_next;
            end
            r_apt_pos <= (r_apt_pos == APT_LAST) ? '0 : r_apt_pos + 1'b1;
        end
    end
`else
    logic [63:0] w_unused_apt;
    assign w_unused_apt = {32'(APT_WINDOW), 32'(APT_CUTOFF)};
    assign w_apt_trip   = 1'b0;
`endif

    assign trng_data    = r_trng_data;
    assign trng_ready   = r_trng_ready;
    assign alarm        = (r_state == ST_ALARM);
    assign health_state = r_state;
    assign fifo_count   = r_count;

endmodule

// File: tb/tb_trng_health_fifo.sv
// Randomized and directed bench for trng_health_fifo against a queue-based reference model.
module tb_trng_health_fifo;
    localparam int DEPTH         = 8;
    localparam int STARTUP_WORDS = 16;
    localparam int RCT_CUTOFF    = 4;
    localparam int APT_WINDOW    = 64;
    localparam int APT_CUTOFF    = 8;
`ifdef TRNG_APT_EN
    localparam bit APT_ON = 1'b1;
`else
    localparam bit APT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] raw_data = '0;
    logic        raw_valid = 1'b0;
    logic        raw_ready;
    logic        trng_request = 1'b0;
    logic [31:0] trng_data;
    logic        trng_ready;
    logic        clear_alarm = 1'b0;
    logic        alarm;
    logic [1:0]  health_state;
    logic [3:0]  fifo_count;

    int errors = 0;
    int checks = 0;

    trng_health_fifo #(
        .DEPTH(DEPTH), .STARTUP_WORDS(STARTUP_WORDS), .RCT_CUTOFF(RCT_CUTOFF),
        .APT_WINDOW(APT_WINDOW), .APT_CUTOFF(APT_CUTOFF)
    ) dut (
        .clk(clk), .rst(rst), .raw_data(raw_data), .raw_valid(raw_valid), .raw_ready(raw_ready),
        .trng_request(trng_request), .trng_data(trng_data), .trng_ready(trng_ready),
        .clear_alarm(clear_alarm), .alarm(alarm), .health_state(health_state), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state 0/1/2, buffered words in a queue, counters as plain integers.
    int          m_state = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_tdata = '0;
    bit          m_tready = 1'b0;
    int          m_start = 0;
    int          m_rct = 0;
    logic [31:0] m_last = '0;
    int          m_apt_pos = 0;
    int          m_apt_cnt = 0;
    logic [31:0] m_apt_ref = '0;
    bit          m_acc = 1'b0;

    function automatic bit model_raw_ready();
        return !rst && (m_q.size() < DEPTH) && (m_state != 2);
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit pop;
        bit trip;
        if (rst) begin
            m_state = 0; m_q.delete(); m_tdata = '0; m_tready = 1'b0;
            m_start = 0; m_rct = 0; m_last = '0;
            m_apt_pos = 0; m_apt_cnt = 0; m_apt_ref = '0; m_acc = 1'b0;
        end else begin
            acc  = raw_valid && model_raw_ready();
            pop  = trng_request && (m_q.size() != 0) && !m_tready && (m_state != 2);
            trip = 1'b0;
            m_tready = pop;
            if (pop) m_tdata = m_q.pop_front();
            if (acc) begin
                m_rct  = (m_rct > 0 && raw_data == m_last) ? m_rct + 1 : 1;
                m_last = raw_data;
                if (m_rct >= RCT_CUTOFF) trip = 1'b1;
                if (APT_ON) begin
                    if (m_apt_pos == 0) begin
                        m_apt_ref = raw_data;
                        m_apt_cnt = 0;
                    end else if (raw_data == m_apt_ref) begin
                        m_apt_cnt++;
                        if (m_apt_cnt >= APT_CUTOFF) trip = 1'b1;
                    end
                    m_apt_pos = (m_apt_pos + 1) % APT_WINDOW;
                end
            end
            if (m_state == 2) begin
                if (clear_alarm) begin
                    m_state = 0; m_start = 0; m_rct = 0; m_last = '0;
                    m_apt_pos = 0; m_apt_cnt = 0; m_apt_ref = '0;
                end
            end else if (trip) begin
                m_state = 2;
                m_q.delete();
            end else if (acc) begin
                if (m_state == 0) begin
                    m_start++;
                    if (m_start == STARTUP_WORDS) m_state = 1;
                end else begin
                    m_q.push_back(raw_data);
                end
            end
            m_acc = acc;
        end
    end

    always @(negedge clk) begin
        check_eq("raw_ready", raw_ready, model_raw_ready());
        check_eq("trng_ready", trng_ready, m_tready);
        check_eq("trng_data", trng_data, m_tdata);
        check_eq("alarm", alarm, (m_state == 2));
        check_eq("health_state", health_state, m_state);
        check_eq("fifo_count", fifo_count, m_q.size());
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feed(input logic [31:0] w);
        int waited = 0;
        raw_data  = w;
        raw_valid = 1'b1;
        do begin
            tick(1);
            waited++;
        end while (!m_acc && waited < 40);
        raw_valid = 1'b0;
        check_eq("feed_accept", m_acc, 1);
    endtask

    task automatic collect(input int cycles, output logic [31:0] got[$]);
        got.delete();
        repeat (cycles) begin
            tick(1);
            if (trng_ready) got.push_back(trng_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        logic [31:0] w;
        int waited;

        // Reset values
        tick(3);
        check_eq("rst_state", health_state, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ready", raw_ready, 0);
        check_eq("rst_alarm", alarm, 0);
        rst = 1'b0;
        tick(1);
        check_eq("post_rst_ready", raw_ready, 1);

        // Startup discard
        for (int i = 1; i <= 16; i++) feed(32'(i));
        check_eq("startup_count", fifo_count, 0);
        check_eq("startup_to_run", health_state, 1);
        for (int i = 17; i <= 19; i++) feed(32'(i));
        tick(1);
        check_eq("run_count3", fifo_count, 3);

        // Drain
        trng_request = 1'b1;
        collect(10, got_q);
        trng_request = 1'b0;
        check_eq("drain_n", got_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check_eq("drain_data", (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF, 32'h11 + i);
        check_eq("drain_empty", fifo_count, 0);

        // Full and concurrent push/pop across pointer wrap
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom | 32'h1;
            exp_q.push_back(w);
            feed(w);
        end
        check_eq("full_count", fifo_count, DEPTH);
        w = $urandom | 32'h1;
        raw_data = w;
        raw_valid = 1'b1;
        tick(2);
        check_eq("full_stall", raw_ready, 0);
        trng_request = 1'b1;
        tick(1);
        trng_request = 1'b0;
        check_eq("full_pop_count", fifo_count, DEPTH - 1);
        check_eq("full_pop_data", trng_data, exp_q[0]);
        waited = 0;
        do begin
            tick(1);
            waited++;
        end while (!m_acc && waited < 10);
        raw_valid = 1'b0;
        check_eq("stalled_accept", m_acc, 1);
        check_eq("refill_count", fifo_count, DEPTH);
        void'(exp_q.pop_front());
        exp_q.push_back(w);
        trng_request = 1'b1;
        collect(24, got_q);
        trng_request = 1'b0;
        check_eq("wrap_n", got_q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++)
            check_eq("wrap_data", (i < got_q.size()) ? got_q[i] : ~exp_q[i], exp_q[i]);

        // RCT trip
        feed($urandom | 32'h1);
        feed($urandom | 32'h1);
        check_eq("rct_pre_count", fifo_count, 2);
        repeat (4) feed(32'hDEAD_BEEF);
        check_eq("rct_alarm", alarm, 1);
        check_eq("rct_flush", fifo_count, 0);
        check_eq("rct_ready", raw_ready, 0);
        trng_request = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq("alarm_no_strobe", trng_ready, 0);
        end
        trng_request = 1'b0;

        // Recovery
        clear_alarm = 1'b1;
        tick(1);
        clear_alarm = 1'b0;
        check_eq("clear_state", health_state, 0);
        check_eq("clear_alarm", alarm, 0);
        for (int i = 0; i < STARTUP_WORDS; i++) feed($urandom | 32'h1);
        check_eq("restart_count", fifo_count, 0);
        feed($urandom | 32'h1);
        check_eq("restart_push", fifo_count, 1);
        clear_alarm = 1'b1;
        tick(1);
        clear_alarm = 1'b0;
        check_eq("clear_ignored", health_state, 1);

        // Reset mid-drain
        for (int i = 0; i < 3; i++) feed($urandom | 32'h1);
        trng_request = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        check_eq("mid_rst_ready", trng_ready, 0);
        check_eq("mid_rst_data", trng_data, 0);
        check_eq("mid_rst_count", fifo_count, 0);
        check_eq("mid_rst_state", health_state, 0);
        check_eq("mid_rst_raw_ready", raw_ready, 0);
        rst = 1'b0;
        trng_request = 1'b0;
        tick(1);

        // Adaptive proportion: non-consecutive repeats of the window reference
        feed(32'hCAFE_0000);
        for (int i = 0; i < APT_CUTOFF; i++) begin
            feed($urandom | 32'h1);
            feed(32'hCAFE_0000);
        end
        check_eq("apt_alarm", alarm, APT_ON);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            raw_valid    = ($urandom_range(0, 3) != 0);
            raw_data     = ($urandom_range(0, 1) != 0) ? 32'(32'h100 + $urandom_range(0, 2)) : $urandom;
            trng_request = ($urandom_range(0, 2) != 0);
            clear_alarm  = ($urandom_range(0, 15) == 0);
            rst          = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        raw_valid = 1'b0;
        trng_request = 1'b0;
        clear_alarm = 1'b0;
        rst = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trng_health_fifo.md
Name: trng_health_fifo

Overview:
- Entropy conditioning stage directly upstream of asic_top.
- Accepts raw 32-bit words from the TRNG source and discards a startup burst.
- Runs an online repetition-count health test and buffers healthy words in a small FIFO.
- Serves asic_top through its trng_request / trng_data / trng_ready handshake; a failed health test latches an alarm and blocks all output.

Parameters:
- DEPTH, 8, FIFO depth in words; power of 2, minimum 2.
- STARTUP_WORDS, 16, accepted raw words discarded after reset or alarm clear.
- RCT_CUTOFF, 4, consecutive identical accepted words that trip the alarm; minimum 2.
- APT_WINDOW, 64, adaptive proportion window length in words (only with TRNG_APT_EN).
- APT_CUTOFF, 8, matches within one window that trip the alarm (only with TRNG_APT_EN).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- raw_data  in  32  raw entropy word.
- raw_valid  in  1  raw_data valid.
- raw_ready  out  1  block accepts raw_data this cycle.
- trng_request  in  1  asic_top wants a word (level).
- trng_data  out  32  random word to asic_top.
- trng_ready  out  1  one-cycle strobe; trng_data valid.
- clear_alarm  in  1  leaves ALARM.
- alarm  out  1  sticky health failure.
- health_state  out  2  0=STARTUP, 1=RUN, 2=ALARM.
- fifo_count  out  $clog2(DEPTH)+1  words buffered.

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset values:
  - State is STARTUP.
  - raw_ready=0 during the reset cycle. After reset, raw_ready is combinational: !full && state!=ALARM.
  - trng_data=0, trng_ready=0, alarm=0, fifo_count=0.
  - All counters and last-word registers cleared.
- Raw accept: raw_valid && raw_ready in a cycle.
- STARTUP:
  - Accepted words are not pushed to the FIFO; they still feed the RCT compare.
  - After the STARTUP_WORDS-th accept, go to RUN on the next edge.
- RUN: accepted words are pushed unless the word trips a health test.
- RCT:
  - rct_cnt=1 on the first accept after reset or clear.
  - On each later accept: rct_cnt+1 if raw_data equals the last accepted word, else 1.
  - rct_cnt reaching RCT_CUTOFF: the tripping word is not pushed, and the next state is ALARM.
  - A trip during STARTUP also goes to ALARM.
- ALARM:
  - On entry the FIFO is flushed, so fifo_count=0 the next cycle.
  - alarm=1, raw_ready=0, trng_ready stays 0 regardless of trng_request.
  - clear_alarm=1 in ALARM: next state STARTUP with startup and RCT counters cleared.
  - clear_alarm in other states is ignored.
- Output handshake:
  - Pop when trng_request && !empty && !trng_ready && state!=ALARM.
  - On a pop, trng_data is registered from the FIFO head and trng_ready=1 on the next cycle only.
  - Latency is 1 cycle from a sampled request to the strobe.
  - With request held high, at most one word every 2 cycles.
  - trng_data holds its value until the next pop.
- Empty FIFO: the request waits and trng_ready stays 0. The first pop is possible in the cycle after a push lands.
- Full FIFO: raw_ready=0, so the source stalls.
- Push and pop in the same cycle: fifo_count is unchanged. Legal when full only if the pop was already committed, because raw_ready depends on the pre-pop full flag.
- FIFO pointers wrap modulo DEPTH; data leaves in FIFO order.
- A trip and a pop in the same cycle: the pop completes (strobe issued), then the flush occurs.
- rst at any time, including mid-handshake, returns everything to reset values on the next edge.

Optional Feature:
- Macro TRNG_APT_EN.
- When defined, an adaptive proportion test also runs on every accept, in all non-ALARM states:
  - The first word of each APT_WINDOW-word window is the reference.
  - Each later word in the window equal to the reference increments apt_cnt.
  - apt_cnt reaching APT_CUTOFF trips ALARM exactly like RCT; the tripping word is not pushed.
  - The window restarts after APT_WINDOW words, on reset, and on clear_alarm.
- When not defined, no APT logic or state exists and the behaviour is RCT only.

Test Plan:
- Startup discard: rst; feed 16 distinct words 0x1..0x10 -> fifo_count=0, health_state goes 0->1; then feed 0x11,0x12,0x13 -> fifo_count=3.
- Drain: 3 words buffered, trng_request held 1 -> trng_ready pulses on alternate cycles with trng_data 0x11,0x12,0x13 in order, fifo_count 3->0, no 4th strobe.
- Full/concurrent: fill 8 words -> raw_ready=0 with raw_valid held; request one word -> fifo_count dips to 7, the stalled word is accepted, back at 8, FIFO order preserved across the pointer wrap.
- RCT trip: in RUN with 2 buffered, feed 0xDEADBEEF four times -> alarm=1 the cycle after the 4th accept, fifo_count=0, raw_ready=0, no trng_ready under a held request.
- Recovery and reset: pulse clear_alarm -> health_state=0, 16 words are needed before any push; assert rst mid-drain -> all outputs at reset values next cycle.
- APT: with TRNG_APT_EN, 0xCAFE0000 as the window start, then 8 non-consecutive repeats within 64 words -> alarm; the same stimulus without the macro -> no alarm.
